// File: rtl/mem_init_pkg.sv
// Shared types for the memory-initialisation sequencer.
// Holds the fill-pattern selector encoding and the sequencer state encoding.
// No logic; imported by mem_init_seq and mem_init_datagen.
package mem_init_pkg;

    // Fill pattern selector, sampled when a pass is started.
    typedef enum logic [1:0] {
        FILL_IDENT = 2'd0,  // data = idx
        FILL_CONST = 2'd1,  // data = fill_value
        FILL_RAMP  = 2'd2,  // data = fill_value + idx (wraps)
        FILL_REV   = 2'd3   // data = DEPTH-1-idx
    } fill_mode_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_init_datagen.sv
// Pattern generator: maps the current write index to the RAM write data.
// Latency: purely combinational (0 cycles).
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   mode       - fill pattern selector (fill_mode_t encoding)
//   fill_value - constant / seed for the pattern
//   idx        - current write index, ADDR_W+1 bits
//   pattern    - data to write at idx, truncated to DATA_W
module mem_init_datagen
    import mem_init_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [ADDR_W:0]   idx,
    output logic [DATA_W-1:0] pattern
);

    // Work in a width that holds both the index and the data so that every
    // pattern is computed exactly and only truncated at the very end.
    localparam int W = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;

    // DEPTH <= 2**ADDR_W, so DEPTH-1 always fits in W bits.
    localparam logic [W-1:0] DEPTH_M1 = W'(DEPTH - 1);

    logic [W-1:0] idx_w;
    logic [W-1:0] fill_w;
    logic [W-1:0] res;

    always_comb begin
        idx_w  = W'(idx);
        fill_w = W'(fill_value);
        res    = idx_w;
        case (fill_mode_t'(mode))
            FILL_IDENT: res = idx_w;
            FILL_CONST: res = fill_w;
            FILL_RAMP:  res = fill_w + idx_w;   // modulo 2**DATA_W after truncation
            FILL_REV:   res = DEPTH_M1 - idx_w; // idx < DEPTH whenever this is used
            default:    res = idx_w;
        endcase
        pattern = DATA_W'(res);
    end

endmodule

// File: rtl/mem_init_seq.sv
// Memory-initialisation sequencer: writes a mode-selected pattern to RAM addresses 0..DEPTH-1.
// Latency: first write visible one cycle after start is accepted; done DEPTH+1 cycles after start.
// Backpressure: stall holds the write sequence for that cycle (no write, index/address/data held).
//
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   start               - begin a pass (accepted in IDLE or DONE only)
//   abort               - return to IDLE on the next edge; wins over start and stall
//   stall               - lend the RAM port to another master this cycle
//   mode, fill_value    - pattern select and seed, captured when start is accepted
//   address, data, wren - registered RAM write port
//   busy, done          - pass in progress / pass completed
module mem_init_seq
    import mem_init_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              done
);

    // The index is one bit wider than the address so that a full-size pass
    // (DEPTH == 2**ADDR_W) reaches DEPTH instead of wrapping back to 0.
    localparam int IW = ADDR_W + 1;
    localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    fill_mode_t        mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;

    logic [DATA_W-1:0] pattern;

    // Pattern is driven from the captured mode/seed, so input changes during
    // a pass have no effect on the data written.
    mem_init_datagen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_datagen (
        .mode       (mode_q),
        .fill_value (fill_q),
        .idx        (idx_q),
        .pattern    (pattern)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;       // a write only happens in the cycle it is issued
        busy_d    = busy_q;
        done_d    = done_q;
        mode_d    = mode_q;
        fill_d    = fill_q;

        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_d  = fill_mode_t'(mode);
                        fill_d  = fill_value;
                        idx_d   = '0;
                        state_d = WRITE;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                WRITE: begin
                    // start is ignored here; stall freezes the sequence,
                    // including the final transition to DONE.
                    if (!stall) begin
                        if (idx_q < DEPTH_IDX) begin
                            address_d = idx_q[ADDR_W-1:0];
                            data_d    = pattern;
                            wren_d    = 1'b1;
                            idx_d     = idx_q + 1'b1;
                        end else begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= FILL_IDENT;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mode_q    <= mode_d;
            fill_q    <= fill_d;
        end
    end

    assign address = address_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_init_seq.sv
// Directed bench for mem_init_seq: a default-size instance and a DEPTH=16 instance.
// Inputs change and outputs are sampled on the falling clock edge.
// Every comparison is an immediate assertion that counts failures.
module tb_mem_init_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, b_start, abort, stall;
    logic [1:0] mode;
    logic [7:0] fill_value;

    logic [7:0] address, data;
    logic       wren, busy, done;
    logic [3:0] b_address;
    logic [7:0] b_data;
    logic       b_wren, b_busy, b_done;

    int vectors = 0;
    int errs    = 0;
    logic [7:0] mem_img [256];

    always #5 clk = ~clk;

    mem_init_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .mode       (mode),
        .fill_value (fill_value),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .done       (done)
    );

    mem_init_seq #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (b_start),
        .abort      (abort),
        .stall      (stall),
        .mode       (mode),
        .fill_value (fill_value),
        .address    (b_address),
        .data       (b_data),
        .wren       (b_wren),
        .busy       (b_busy),
        .done       (b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected data for write number i of a 256-deep pass.
    function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] fv, input int i);
        logic [7:0] iv;
        iv = 8'(i);
        case (m)
            2'd0:    return iv;
            2'd1:    return fv;
            2'd2:    return 8'(fv + iv);
            default: return 8'(255 - i);
        endcase
    endfunction

    // Starts a pass on the default instance from the falling edge and follows it
    // to done, checking every write. stall_at < 0 disables the stall window.
    task automatic run_pass(input logic [1:0] m, input logic [7:0] fv,
                            input int stall_at, input int stall_n,
                            output int cyc, output int nwr);
        int sc;
        bit prev_stall;
        mode = m; fill_value = fv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~m; fill_value = ~fv;   // must not affect the running pass
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_wren", wren, 0);
        cyc = 0; nwr = 0; sc = 0; prev_stall = 1'b0;
        while (!done && cyc < 2000) begin
            if (prev_stall) begin
                chk("stall_wren", wren, 0);
                chk("stall_addr", address, stall_at - 1);
            end
            if (wren) begin
                chk("wr_addr", address, nwr);
                chk("wr_data", data, model(m, fv, nwr));
                mem_img[address] = data;
                nwr++;
            end
            prev_stall = (stall_at >= 0) && (nwr == stall_at) && (sc < stall_n);
            if (prev_stall) sc++;
            stall = prev_stall;
            @(negedge clk);
            cyc++;
        end
        stall = 1'b0;
        chk("pass_done", done, 1);
        chk("pass_wren_at_done", wren, 0);
        chk("pass_busy_at_done", busy, 0);
    endtask

    initial begin
        int cyc, nwr, n;
        start = 0; b_start = 0; abort = 0; stall = 0; mode = 0; fill_value = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_address", address, 0);
        chk("rst_data", data, 0);
        chk("rst_wren", wren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_wren", wren, 0);

        // 1: identity fill
        run_pass(2'd0, 8'h00, -1, 0, cyc, nwr);
        chk("t1_done_cycle", cyc, 257);
        chk("t1_wren_count", nwr, 256);
        chk("t1_addr_255", mem_img[255], 8'hFF);
        @(negedge clk);
        chk("t1_done_hold", done, 1);
        chk("t1_done_wren", wren, 0);

        // 2: ramp with wrap, then reverse
        run_pass(2'd2, 8'hF0, -1, 0, cyc, nwr);
        chk("t2_ramp_0f", mem_img[8'h0F], 8'hFF);
        chk("t2_ramp_10", mem_img[8'h10], 8'h00);
        chk("t2_ramp_00", mem_img[8'h00], 8'hF0);
        run_pass(2'd3, 8'h00, -1, 0, cyc, nwr);
        chk("t2_rev_0", mem_img[0], 8'hFF);
        chk("t2_rev_255", mem_img[255], 8'h00);
        chk("t2_rev_count", nwr, 256);

        // 3: three stall cycles at idx 10
        run_pass(2'd0, 8'h00, 10, 3, cyc, nwr);
        chk("t3_done_cycle", cyc, 260);
        chk("t3_wren_count", nwr, 256);

        // 4: abort together with start at idx 100
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 0; cyc = 0;
        while (cyc < 500) begin
            if (wren) n++;
            if (n == 100) break;
            @(negedge clk);
            cyc++;
        end
        chk("t4_reached_idx100", n, 100);
        chk("t4_addr_99", address, 99);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("t4_abort_wren", wren, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        @(negedge clk);
        chk("t4_idle_wren", wren, 0);
        chk("t4_idle_busy", busy, 0);
        run_pass(2'd0, 8'h00, -1, 0, cyc, nwr);
        chk("t4_restart_count", nwr, 256);

        // 5: small instance, constant fill
        mode = 2'd1; fill_value = 8'h5A; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0; mode = 2'd0; fill_value = 8'h00;
        chk("t5_busy", b_busy, 1);
        cyc = 0; n = 0;
        while (!b_done && cyc < 100) begin
            if (b_wren) begin
                chk("t5_addr", b_address, n);
                chk("t5_data", b_data, 8'h5A);
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("t5_count", n, 16);
        chk("t5_done_cycle", cyc, 17);
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_wrap_wren", b_wren, 0);
            chk("t5_no_wrap_addr", b_address, 4'hF);
        end

        // 6: asynchronous reset mid-pass
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 0; cyc = 0;
        while (cyc < 500) begin
            if (wren) n++;
            if (n == 50) break;
            @(negedge clk);
            cyc++;
        end
        chk("t6_reached_idx50", n, 50);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_address", address, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_wren", wren, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_post_rst_wren", wren, 0);
            chk("t6_post_rst_busy", busy, 0);
        end
        run_pass(2'd1, 8'hC3, -1, 0, cyc, nwr);
        chk("t6_const_count", nwr, 256);
        chk("t6_const_mid", mem_img[128], 8'hC3);
        // start from DONE: run_pass checks that done drops
        run_pass(2'd0, 8'h00, -1, 0, cyc, nwr);
        chk("t6_rerun_cycle", cyc, 257);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
